// File: rtl/accel_bus_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accel_bus_pkg                                                        |
// | Shared word type, width and status-word bit positions for the bridge.|
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
package accel_bus_pkg;

  localparam int WORD_W = 16;

  localparam int STAT_OVF    = 15;
  localparam int STAT_UDF    = 14;
  localparam int STAT_CFULL  = 13;
  localparam int STAT_REMPTY = 12;

  typedef logic [WORD_W-1:0] bus_word_t;

  function automatic logic [3:0] sat4(input logic [7:0] c);
    return (c > 8'd15) ? 4'hF : c[3:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_bus_bridge_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accel_bus_bridge_if                                                  |
// | CPU-side and accelerator-side bus signals of the bridge.             |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
interface accel_bus_bridge_if;
  import accel_bus_pkg::*;

  logic      cpu_wr_en;
  bus_word_t cpu_wr_data;
  logic      cpu_rd_en;
  bus_word_t cpu_rd_data;
  logic      acc_cmd_valid;
  bus_word_t acc_cmd_data;
  logic      acc_cmd_ready;
  logic      acc_rsp_valid;
  bus_word_t acc_rsp_data;
  logic      acc_rsp_ready;
  logic      cmd_full;
  logic      rsp_empty;
  logic      err_ovf;
  logic      err_udf;

  modport slave (
    input  cpu_wr_en, cpu_wr_data, cpu_rd_en, acc_cmd_ready, acc_rsp_valid, acc_rsp_data,
    output cpu_rd_data, acc_cmd_valid, acc_cmd_data, acc_rsp_ready, cmd_full, rsp_empty,
           err_ovf, err_udf
  );

  modport master (
    output cpu_wr_en, cpu_wr_data, cpu_rd_en, acc_cmd_ready, acc_rsp_valid, acc_rsp_data,
    input  cpu_rd_data, acc_cmd_valid, acc_cmd_data, acc_rsp_ready, cmd_full, rsp_empty,
           err_ovf, err_udf
  );

endinterface
`default_nettype wire

// File: rtl/accel_bus_bridge_sync_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo                                                            |
// | First-word-fall-through FIFO with wrap-bit pointers.                 |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     i_push,
  input  wire                     i_pop,
  input  wire  [WIDTH-1:0]        i_wdata,
  output logic [WIDTH-1:0]        o_rdata,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
      if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr[AW-1:0]];
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign o_empty = (r_wptr == r_rptr);
  assign o_count = r_wptr - r_rptr;

endmodule
`default_nettype wire

// File: rtl/accel_bus_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | accel_bus_bridge                                                     |
// | CPU bus <-> NN accelerator bridge with command/response FIFOs.       |
// | Optional macro ACCEL_BRIDGE_STATUS_EN: empty reads return status and |
// | clear the sticky error flags.                                        |
// | Rev 1.0  initial release                                             |
// +----------------------------------------------------------------------+
module accel_bus_bridge
  import accel_bus_pkg::*;
#(
  parameter int WORD_W    = accel_bus_pkg::WORD_W,
  parameter int CMD_DEPTH = 8,
  parameter int RSP_DEPTH = 8
) (
  input wire                  clk,
  input wire                  rst_n,
  accel_bus_bridge_if.slave   bus
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  logic              w_cmd_push, w_cmd_pop, w_cmd_full, w_cmd_empty;
  logic              w_rsp_push, w_rsp_pop, w_rsp_full, w_rsp_empty;
  logic [WORD_W-1:0] w_cmd_head, w_rsp_head;
  logic [CAW:0]      w_cmd_count;
  logic [RAW:0]      w_rsp_count;
  logic              w_ovf_event, w_udf_read;
  logic              r_err_ovf, r_err_udf;

  assign w_cmd_pop   = !w_cmd_empty && bus.acc_cmd_ready;
  assign w_cmd_push  = bus.cpu_wr_en && (!w_cmd_full || w_cmd_pop);
  assign w_rsp_push  = bus.acc_rsp_valid && !w_rsp_full;
  assign w_rsp_pop   = bus.cpu_rd_en && !w_rsp_empty;
  assign w_ovf_event = bus.cpu_wr_en && w_cmd_full && !w_cmd_pop;
  assign w_udf_read  = bus.cpu_rd_en && w_rsp_empty;

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_cmd_push),
    .i_pop   (w_cmd_pop),
    .i_wdata (bus.cpu_wr_data),
    .o_rdata (w_cmd_head),
    .o_full  (w_cmd_full),
    .o_empty (w_cmd_empty),
    .o_count (w_cmd_count)
  );

  sync_fifo #(.WIDTH(WORD_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_rsp_push),
    .i_pop   (w_rsp_pop),
    .i_wdata (bus.acc_rsp_data),
    .o_rdata (w_rsp_head),
    .o_full  (w_rsp_full),
    .o_empty (w_rsp_empty),
    .o_count (w_rsp_count)
  );

`ifdef ACCEL_BRIDGE_STATUS_EN
  logic [WORD_W-1:0] w_status;

  always_comb begin
    w_status              = '0;
    w_status[STAT_OVF]    = r_err_ovf;
    w_status[STAT_UDF]    = r_err_udf;
    w_status[STAT_CFULL]  = w_cmd_full;
    w_status[STAT_REMPTY] = 1'b1;
    w_status[11:8]        = sat4(8'(w_cmd_count));
    w_status[7:4]         = sat4(8'(w_rsp_count));
  end

  // A status read clears both flags; an overflow in that same cycle still wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else if (w_udf_read) begin
      r_err_ovf <= w_ovf_event;
      r_err_udf <= 1'b0;
    end else begin
      if (w_ovf_event) r_err_ovf <= 1'b1;
    end
  end

  assign bus.cpu_rd_data = w_rsp_empty ? (bus.cpu_rd_en ? w_status : '0) : w_rsp_head;
`else
  logic w_unused_counts;
  assign w_unused_counts = ^{w_cmd_count, w_rsp_count};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_ovf <= 1'b0;
      r_err_udf <= 1'b0;
    end else begin
      if (w_ovf_event) r_err_ovf <= 1'b1;
      if (w_udf_read)  r_err_udf <= 1'b1;
    end
  end

  assign bus.cpu_rd_data = w_rsp_empty ? '0 : w_rsp_head;
`endif

  assign bus.acc_cmd_valid = !w_cmd_empty;
  assign bus.acc_cmd_data  = w_cmd_head;
  assign bus.acc_rsp_ready = !w_rsp_full;
  assign bus.cmd_full      = w_cmd_full;
  assign bus.rsp_empty     = w_rsp_empty;
  assign bus.err_ovf       = r_err_ovf;
  assign bus.err_udf       = r_err_udf;

endmodule
`default_nettype wire

// File: tb/tb_accel_bus_bridge.sv
`default_nettype none
// Directed testbench for accel_bus_bridge: FIFO order, stalls, full/empty
// boundaries, sticky flags and asynchronous reset.
module tb_accel_bus_bridge;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  accel_bus_bridge_if bus();

  accel_bus_bridge u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".valid"},  16'(bus.acc_cmd_valid), 16'h0);
    chk({tag, ".cfull"},  16'(bus.cmd_full),      16'h0);
    chk({tag, ".rempty"}, 16'(bus.rsp_empty),     16'h1);
    chk({tag, ".rready"}, 16'(bus.acc_rsp_ready), 16'h1);
    chk({tag, ".rdata"},  bus.cpu_rd_data,        16'h0);
    chk({tag, ".ovf"},    16'(bus.err_ovf),       16'h0);
    chk({tag, ".udf"},    16'(bus.err_udf),       16'h0);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.cpu_wr_en     = 1'b0;
    bus.cpu_wr_data   = '0;
    bus.cpu_rd_en     = 1'b0;
    bus.acc_cmd_ready = 1'b0;
    bus.acc_rsp_valid = 1'b0;
    bus.acc_rsp_data  = '0;
    #1;
    chk_reset_outputs("reset");
    tick();
    tick();
    rst_n = 1'b1;

    // 1: single write, held under stall, popped on ready
    bus.cpu_wr_en = 1'b1; bus.cpu_wr_data = 16'h1234;
    chk("t1.valid_before", 16'(bus.acc_cmd_valid), 16'h0);
    tick();
    bus.cpu_wr_en = 1'b0;
    chk("t1.valid", 16'(bus.acc_cmd_valid), 16'h1);
    chk("t1.data",  bus.acc_cmd_data, 16'h1234);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1.hold", bus.acc_cmd_data, 16'h1234);
    end
    bus.acc_cmd_ready = 1'b1;
    tick();
    bus.acc_cmd_ready = 1'b0;
    chk("t1.popped", 16'(bus.acc_cmd_valid), 16'h0);

    // 2: overflow on the ninth write, drain order
    for (int i = 1; i <= 9; i++) begin
      bus.cpu_wr_en = 1'b1; bus.cpu_wr_data = 16'(i);
      tick();
      if (i == 7) chk("t2.notfull7", 16'(bus.cmd_full), 16'h0);
      if (i == 8) chk("t2.full8",    16'(bus.cmd_full), 16'h1);
    end
    bus.cpu_wr_en = 1'b0;
    chk("t2.ovf",  16'(bus.err_ovf),  16'h1);
    chk("t2.full", 16'(bus.cmd_full), 16'h1);
    bus.acc_cmd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t2.drain", bus.acc_cmd_data, 16'(i));
      tick();
    end
    bus.acc_cmd_ready = 1'b0;
    chk("t2.empty", 16'(bus.acc_cmd_valid), 16'h0);

    // 3: two responses, zero-latency reads
    bus.acc_rsp_valid = 1'b1; bus.acc_rsp_data = 16'hA5A5;
    tick();
    chk("t3.nonempty1", 16'(bus.rsp_empty), 16'h0);
    bus.acc_rsp_data = 16'h5A5A;
    tick();
    bus.acc_rsp_valid = 1'b0;
    bus.cpu_rd_en = 1'b1;
    chk("t3.rd0", bus.cpu_rd_data, 16'hA5A5);
    tick();
    chk("t3.rd1", bus.cpu_rd_data, 16'h5A5A);
    tick();
    bus.cpu_rd_en = 1'b0;
    chk("t3.empty", 16'(bus.rsp_empty), 16'h1);
    chk("t3.udf_clean", 16'(bus.err_udf), 16'h0);

    // 4: empty read (err_ovf is still set from test 2)
    bus.cpu_rd_en = 1'b1;
`ifdef ACCEL_BRIDGE_STATUS_EN
    chk("t4.status1", bus.cpu_rd_data, 16'h9000);
    tick();
    chk("t4.status2", bus.cpu_rd_data, 16'h1000);
    tick();
    bus.cpu_rd_en = 1'b0;
    chk("t4.ovf_clr", 16'(bus.err_ovf), 16'h0);
    chk("t4.udf_clr", 16'(bus.err_udf), 16'h0);
`else
    chk("t4.rd_zero", bus.cpu_rd_data, 16'h0000);
    tick();
    bus.cpu_rd_en = 1'b0;
    chk("t4.udf", 16'(bus.err_udf), 16'h1);
    chk("t4.ovf_sticky", 16'(bus.err_ovf), 16'h1);
`endif

    // 5: write into full FIFO with same-cycle pop; response full / ready
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.cpu_wr_en = 1'b1; bus.cpu_wr_data = 16'h0010 + 16'(i);
      tick();
    end
    chk("t5.full", 16'(bus.cmd_full), 16'h1);
    bus.cpu_wr_data = 16'h0077; bus.acc_cmd_ready = 1'b1;
    tick();
    bus.cpu_wr_en = 1'b0; bus.acc_cmd_ready = 1'b0;
    chk("t5.still_full", 16'(bus.cmd_full), 16'h1);
    chk("t5.no_ovf",     16'(bus.err_ovf),  16'h0);
    bus.acc_cmd_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t5.drain", bus.acc_cmd_data, (i == 8) ? 16'h0077 : 16'h0010 + 16'(i));
      tick();
    end
    bus.acc_cmd_ready = 1'b0;
    chk("t5.cmd_empty", 16'(bus.acc_cmd_valid), 16'h0);

    bus.acc_rsp_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.acc_rsp_data = 16'h00B0 + 16'(i);
      tick();
    end
    bus.acc_rsp_valid = 1'b0;
    chk("t5.rready_lo", 16'(bus.acc_rsp_ready), 16'h0);
    bus.cpu_rd_en = 1'b1;
    chk("t5.rd_head", bus.cpu_rd_data, 16'h00B0);
    chk("t5.rready_nocomb", 16'(bus.acc_rsp_ready), 16'h0);
    tick();
    bus.cpu_rd_en = 1'b0;
    chk("t5.rready_hi", 16'(bus.acc_rsp_ready), 16'h1);
    chk("t5.rd_next", bus.cpu_rd_data, 16'h00B1);

    // 6: asynchronous reset with buffered words
    do_reset();
    bus.acc_rsp_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.cpu_wr_en = 1'b1; bus.cpu_wr_data = 16'h0C00 + 16'(i);
      bus.acc_rsp_data = 16'h0D00 + 16'(i);
      if (i == 2) bus.acc_rsp_valid = 1'b0;
      tick();
    end
    bus.cpu_wr_en = 1'b0;
    chk("t6.pre_valid",  16'(bus.acc_cmd_valid), 16'h1);
    chk("t6.pre_rempty", 16'(bus.rsp_empty),     16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("t6.async");
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6.post_valid",  16'(bus.acc_cmd_valid), 16'h0);
    chk("t6.post_rempty", 16'(bus.rsp_empty),     16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
